// File: rtl/imem_responder.sv
// Instruction-memory responder for a two-wide fetch stage: fixed-latency dual-word
// reads, credit-gated acceptance and a show-ahead response buffer that absorbs stalls.
module imem_responder #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 256,
  parameter int unsigned     LATENCY     = 2,
  parameter int unsigned     Q_DEPTH     = 4,
  parameter logic [XLEN-1:0] NOP_WORD    = 32'hD503201F
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_ren,
  input  logic [XLEN-1:0] imem_addr0,
  input  logic [XLEN-1:0] imem_addr1,
  output logic            imem_gnt,
  output logic            imem_valid,
  output logic [XLEN-1:0] imem_rdata0,
  output logic [XLEN-1:0] imem_rdata1,
  output logic [XLEN-1:0] imem_pc [2],
  output logic [1:0]      imem_err,
  input  logic            resp_ready,
  input  logic            flush,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_wdata
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = $clog2(Q_DEPTH + 1);

  typedef struct packed {
    logic            valid;
    logic [1:0]      err;
    logic [XLEN-1:0] pc1;
    logic [XLEN-1:0] pc0;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d0;
  } resp_t;

  localparam resp_t RESP_NULL = resp_t'({$bits(resp_t){1'b0}});

  logic [XLEN-1:0] mem_r [DEPTH_WORDS];
  resp_t           stg_r [LATENCY];
  resp_t           fifo_r [Q_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   fifo_cnt_r;
  logic [CW-1:0]   out_cnt_r;
  logic            head_valid_r;

  resp_t           req_s;
  logic            acc_s;
  logic            pop_s;
  logic            push_s;
  logic [CW-1:0]   fifo_cnt_next_s;
  logic [CW-1:0]   out_cnt_next_s;

  // Byte-address comparison is equivalent to word index >= DEPTH_WORDS.
  function automatic logic out_of_range(input logic [XLEN-1:0] a);
    return a >= XLEN'(DEPTH_WORDS * 4);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(Q_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Grant, pop/push qualification, array read and counter next-state.
  always_comb begin
    imem_gnt  = imem_ren && (flush || (out_cnt_r < CW'(Q_DEPTH)));
    acc_s     = imem_gnt;
    pop_s     = head_valid_r && resp_ready && !flush;
    push_s    = stg_r[LATENCY-1].valid && !flush;

    req_s       = RESP_NULL;
    req_s.valid = acc_s;
    req_s.err   = {out_of_range(imem_addr1), out_of_range(imem_addr0)};
    req_s.pc0   = imem_addr0;
    req_s.pc1   = imem_addr1;
    if (req_s.err[0]) begin
      req_s.d0 = NOP_WORD;
    end else begin
      req_s.d0 = mem_r[imem_addr0[AW+1:2]];
    end
    if (req_s.err[1]) begin
      req_s.d1 = NOP_WORD;
    end else begin
      req_s.d1 = mem_r[imem_addr1[AW+1:2]];
    end

    case ({push_s, pop_s})
      2'b10:   fifo_cnt_next_s = fifo_cnt_r + CW'(1);
      2'b01:   fifo_cnt_next_s = fifo_cnt_r - CW'(1);
      default: fifo_cnt_next_s = fifo_cnt_r;
    endcase

    // A pop only returns credit from the following cycle, since grant ignores it.
    case ({acc_s, pop_s})
      2'b10:   out_cnt_next_s = out_cnt_r + CW'(1);
      2'b01:   out_cnt_next_s = out_cnt_r - CW'(1);
      default: out_cnt_next_s = out_cnt_r;
    endcase
  end

  // Program-load write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (prog_we && !out_of_range(prog_addr)) begin
      mem_r[prog_addr[AW+1:2]] <= prog_wdata;
    end
  end

  // Read register plus LATENCY-1 delay stages; a same-edge request survives a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stg_r[i] <= RESP_NULL;
      end
    end else begin
      stg_r[0] <= req_s;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stg_r[i] <= flush ? RESP_NULL : stg_r[i-1];
      end
    end
  end

  // Show-ahead response buffer; credit gating guarantees a push always has room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(Q_DEPTH); i++) begin
        fifo_r[i] <= RESP_NULL;
      end
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      fifo_cnt_r   <= {CW{1'b0}};
      head_valid_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      fifo_cnt_r   <= {CW{1'b0}};
      head_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= stg_r[LATENCY-1];
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      fifo_cnt_r   <= fifo_cnt_next_s;
      head_valid_r <= (fifo_cnt_next_s != {CW{1'b0}});
    end
  end

  // Outstanding count covers pipeline and buffer; flush keeps only a same-edge accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt_r <= {CW{1'b0}};
    end else if (flush) begin
      out_cnt_r <= acc_s ? CW'(1) : {CW{1'b0}};
    end else begin
      out_cnt_r <= out_cnt_next_s;
    end
  end

  assign imem_valid  = head_valid_r;
  assign imem_rdata0 = fifo_r[rd_ptr_r].d0;
  assign imem_rdata1 = fifo_r[rd_ptr_r].d1;
  assign imem_pc[0]  = fifo_r[rd_ptr_r].pc0;
  assign imem_pc[1]  = fifo_r[rd_ptr_r].pc1;
  assign imem_err    = fifo_r[rd_ptr_r].err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (LATENCY=2, Q_DEPTH=4, DEPTH_WORDS=256).
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_ren = 1'b0;
  logic [31:0] imem_addr0 = 32'h0;
  logic [31:0] imem_addr1 = 32'h0;
  logic        imem_gnt;
  logic        imem_valid;
  logic [31:0] imem_rdata0;
  logic [31:0] imem_rdata1;
  logic [31:0] imem_pc [2];
  logic [1:0]  imem_err;
  logic        resp_ready = 1'b1;
  logic        flush = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = 32'h0;
  logic [31:0] prog_wdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  imem_responder #(
    .XLEN(32), .DEPTH_WORDS(256), .LATENCY(2), .Q_DEPTH(4), .NOP_WORD(32'hD503201F)
  ) dut (
    .clk(clk), .reset(reset), .imem_ren(imem_ren), .imem_addr0(imem_addr0),
    .imem_addr1(imem_addr1), .imem_gnt(imem_gnt), .imem_valid(imem_valid),
    .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1), .imem_pc(imem_pc),
    .imem_err(imem_err), .resp_ready(resp_ready), .flush(flush), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    step();
    prog_we = 1'b0;
  endtask

  // Program image as loaded at the start (word 1 is only rewritten in the last tests).
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h8B020000;
      32'h4:   return 32'h910003E1;
      32'h8:   return 32'hF8400022;
      32'hC:   return 32'hF8000023;
      32'h10:  return 32'h14000002;
      32'h14:  return 32'hB4000044;
      default: return 32'hXXXXXXXX;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; imem_ren = 1'b1; imem_addr0 = 32'h0; imem_addr1 = 32'h4;
    #2;
    n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", imem_valid); end
    n_checks++; if (imem_rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h want 0", imem_rdata0); end
    n_checks++; if (imem_rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h want 0", imem_rdata1); end
    n_checks++; if (imem_pc[0] !== 32'h0 || imem_pc[1] !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h/%h want 0/0", imem_pc[0], imem_pc[1]); end
    n_checks++; if (imem_err !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", imem_err); end
    n_checks++; if (imem_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt got %b want 1", imem_gnt); end
    step(); step();
    imem_ren = 1'b0; reset = 1'b1;
    step();
    n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b want 0", imem_valid); end
  endtask

  task automatic test_single();
    resp_ready = 1'b1; imem_ren = 1'b1; imem_addr0 = 32'h0; imem_addr1 = 32'h4;
    #1;
    n_checks++; if (imem_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt got %b want 1", imem_gnt); end
    step();
    imem_ren = 1'b0;
    n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1 got %b want 0", imem_valid); end
    step();
    n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat2 got %b want 0", imem_valid); end
    step();
    n_checks++; if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", imem_valid); end
    n_checks++; if (imem_rdata0 !== 32'h8B020000) begin n_fail++; $display("FAIL single_rdata0 got %h want 8b020000", imem_rdata0); end
    n_checks++; if (imem_rdata1 !== 32'h910003E1) begin n_fail++; $display("FAIL single_rdata1 got %h want 910003e1", imem_rdata1); end
    n_checks++; if (imem_pc[0] !== 32'h0 || imem_pc[1] !== 32'h4) begin n_fail++; $display("FAIL single_pc got %h/%h want 0/4", imem_pc[0], imem_pc[1]); end
    n_checks++; if (imem_err !== 2'b00) begin n_fail++; $display("FAIL single_err got %b want 00", imem_err); end
    step();
    n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL single_popped got %b want 0", imem_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0 [3] = '{32'h0, 32'h8, 32'h10};
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        imem_ren = 1'b1; imem_addr0 = a0[i]; imem_addr1 = a0[i] + 32'h4;
        #1;
        n_checks++; if (imem_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d got %b want 1", i, imem_gnt); end
      end else begin
        imem_ren = 1'b0;
      end
      step();
      if (i >= 2 && i < 5) begin
        n_checks++;
        if (imem_valid !== 1'b1 || imem_pc[0] !== a0[i-2] || imem_rdata0 !== exp_word(a0[i-2]) ||
            imem_rdata1 !== exp_word(a0[i-2] + 32'h4)) begin
          n_fail++;
          $display("FAIL b2b_resp%0d got v=%b pc0=%h d0=%h d1=%h want v=1 pc0=%h d0=%h d1=%h", i - 2,
                   imem_valid, imem_pc[0], imem_rdata0, imem_rdata1, a0[i-2], exp_word(a0[i-2]),
                   exp_word(a0[i-2] + 32'h4));
        end
      end
    end
    n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %b want 0", imem_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] acc_q [$];
    logic [31:0] a;
    int idx;
    a = 32'h0;
    resp_ready = 1'b0; imem_ren = 1'b1;
    for (int c = 0; c < 8; c++) begin
      imem_addr0 = a; imem_addr1 = a + 32'h4;
      #1;
      n_checks++; if (imem_gnt !== (c < 4)) begin n_fail++; $display("FAIL bp_gnt_cycle%0d got %b want %b", c, imem_gnt, (c < 4)); end
      if (imem_gnt === 1'b1) begin
        acc_q.push_back(a);
        a = (a == 32'h10) ? 32'h0 : a + 32'h8;
      end
      step();
    end
    n_checks++; if (imem_valid !== 1'b1 || imem_pc[0] !== acc_q[0]) begin n_fail++; $display("FAIL bp_head got v=%b pc0=%h want v=1 pc0=%h", imem_valid, imem_pc[0], acc_q[0]); end
    resp_ready = 1'b1; imem_addr0 = a; imem_addr1 = a + 32'h4;
    #1;
    n_checks++; if (imem_gnt !== 1'b0) begin n_fail++; $display("FAIL bp_gnt_at_pop got %b want 0", imem_gnt); end
    step();
    resp_ready = 1'b0;
    void'(acc_q.pop_front());
    n_checks++; if (imem_gnt !== 1'b1) begin n_fail++; $display("FAIL bp_credit got %b want 1", imem_gnt); end
    if (imem_gnt === 1'b1) acc_q.push_back(a);
    step();
    n_checks++; if (imem_gnt !== 1'b0) begin n_fail++; $display("FAIL bp_full_again got %b want 0", imem_gnt); end
    imem_ren = 1'b0; resp_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (imem_valid === 1'b1) begin
        n_checks++;
        if (idx >= acc_q.size() || imem_pc[0] !== acc_q[idx] || imem_rdata0 !== exp_word(acc_q[idx])) begin
          n_fail++;
          $display("FAIL bp_order%0d got pc0=%h d0=%h want pc0=%h", idx, imem_pc[0], imem_rdata0,
                   (idx < acc_q.size()) ? acc_q[idx] : 32'hFFFFFFFF);
        end
        idx++;
      end
      step();
    end
    n_checks++; if (idx != 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", idx); end
  endtask

  task automatic test_flush();
    logic [31:0] a0 [3] = '{32'h0, 32'h8, 32'h0};
    int cnt;
    resp_ready = 1'b0; imem_ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_addr0 = a0[i]; imem_addr1 = a0[i] + 32'h4;
      step();
    end
    imem_addr0 = 32'h10; imem_addr1 = 32'h14; flush = 1'b1;
    #1;
    n_checks++; if (imem_gnt !== 1'b1) begin n_fail++; $display("FAIL flush_gnt got %b want 1", imem_gnt); end
    step();
    flush = 1'b0; imem_ren = 1'b0;
    n_checks++; if (imem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", imem_valid); end
    resp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_valid === 1'b1) begin
        if (cnt == 0) begin
          n_checks++;
          if (imem_pc[0] !== 32'h10 || imem_rdata0 !== 32'h14000002) begin
            n_fail++; $display("FAIL flush_first got pc0=%h d0=%h want pc0=00000010 d0=14000002", imem_pc[0], imem_rdata0);
          end
        end
        cnt++;
      end
      step();
    end
    n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL flush_count got %0d want 1", cnt); end
  endtask

  task automatic test_out_of_range();
    resp_ready = 1'b1;
    prog(32'h400, 32'hFFFFFFFF);
    imem_ren = 1'b1; imem_addr0 = 32'h3FC; imem_addr1 = 32'h400;
    step();
    imem_addr0 = 32'h0; imem_addr1 = 32'h4;
    step();
    imem_ren = 1'b0;
    for (int k = 0; k < 8 && imem_valid !== 1'b1; k++) step();
    n_checks++; if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL oor_timeout got %b want 1", imem_valid); end
    n_checks++; if (imem_rdata0 !== 32'h12345678) begin n_fail++; $display("FAIL oor_slot0 got %h want 12345678", imem_rdata0); end
    n_checks++; if (imem_rdata1 !== 32'hD503201F) begin n_fail++; $display("FAIL oor_nop got %h want d503201f", imem_rdata1); end
    n_checks++; if (imem_err !== 2'b10) begin n_fail++; $display("FAIL oor_err got %b want 10", imem_err); end
    n_checks++; if (imem_pc[1] !== 32'h400) begin n_fail++; $display("FAIL oor_pc1 got %h want 00000400", imem_pc[1]); end
    step();
    n_checks++; if (imem_valid !== 1'b1 || imem_rdata0 !== 32'h8B020000 || imem_err !== 2'b00) begin
      n_fail++; $display("FAIL oor_write_ignored got v=%b d0=%h err=%b want v=1 d0=8b020000 err=00", imem_valid, imem_rdata0, imem_err);
    end
    step();
  endtask

  task automatic test_prog_collision();
    resp_ready = 1'b1;
    imem_ren = 1'b1; imem_addr0 = 32'h0; imem_addr1 = 32'h4;
    prog_we = 1'b1; prog_addr = 32'h4; prog_wdata = 32'hDEADBEEF;
    step();
    prog_we = 1'b0;
    step();
    imem_ren = 1'b0;
    for (int k = 0; k < 8 && imem_valid !== 1'b1; k++) step();
    n_checks++; if (imem_valid !== 1'b1 || imem_rdata1 !== 32'h910003E1) begin n_fail++; $display("FAIL coll_old got v=%b d1=%h want v=1 d1=910003e1", imem_valid, imem_rdata1); end
    step();
    n_checks++; if (imem_valid !== 1'b1 || imem_rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL coll_new got v=%b d1=%h want v=1 d1=deadbeef", imem_valid, imem_rdata1); end
    step();
  endtask

  task automatic test_reset_midstream();
    int cnt;
    resp_ready = 1'b0; imem_ren = 1'b1;
    imem_addr0 = 32'h8; imem_addr1 = 32'hC;
    step();
    imem_addr0 = 32'h0; imem_addr1 = 32'h4;
    step();
    imem_ren = 1'b0;
    step(); step();
    n_checks++; if (imem_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got %b want 1", imem_valid); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (imem_valid !== 1'b0 || imem_rdata0 !== 32'h0) begin n_fail++; $display("FAIL mid_async got v=%b d0=%h want v=0 d0=0", imem_valid, imem_rdata0); end
    step();
    reset = 1'b1; resp_ready = 1'b1;
    imem_ren = 1'b1; imem_addr0 = 32'h10; imem_addr1 = 32'h14;
    step();
    imem_ren = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_valid === 1'b1) begin
        n_checks++;
        if (imem_pc[0] !== 32'h10 || imem_rdata0 !== 32'h14000002) begin
          n_fail++; $display("FAIL mid_resp got pc0=%h d0=%h want pc0=00000010 d0=14000002", imem_pc[0], imem_rdata0);
        end
        cnt++;
      end
      step();
    end
    n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL mid_count got %0d want 1", cnt); end
  endtask

  initial begin
    test_reset();
    prog(32'h0, 32'h8B020000);
    prog(32'h4, 32'h910003E1);
    prog(32'h8, 32'hF8400022);
    prog(32'hC, 32'hF8000023);
    prog(32'h10, 32'h14000002);
    prog(32'h14, 32'hB4000044);
    prog(32'h3FC, 32'h12345678);
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_out_of_range();
    test_prog_collision();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
